// File: rtl/qs_ucode_store.sv
// Microcode control store.
// After reset every entry is filled with FILL, one entry per cycle.
// Once filled, the store serves one lookup per cycle with a registered read.
// It also accepts program-load writes unless lock is asserted.
module qs_ucode_store #(
    parameter int             DEPTH = 256,
    parameter int             W     = 16,
    parameter logic [W-1:0]   FILL  = 16'h1080,
    parameter int             AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ra_vld,
    input  logic [AW-1:0] ra,
    output logic          rout_vld,
    output logic [W-1:0]  rout,
    input  logic          wr_vld,
    output logic          wr_rdy,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          lock,
    output logic          init_done
);

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [AW-1:0]   cnt_reg;
    logic [AW-1:0]   cnt_next;
    logic            init_done_reg;
    logic            rout_vld_reg;
    logic [W-1:0]    rout_reg;

    // Memory write port controls, shared between the fill sweep and program load.
    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [W-1:0]    mem_wd;
    logic            rd_accept;

    // No reset on the array so it maps onto block RAM; INIT rewrites every entry.
    logic [W-1:0]    mem [DEPTH];

    // State, fill counter and init_done registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= INIT;
            cnt_reg       <= '0;
            init_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            init_done_reg <= (state_next == READY);
        end
    end

    // Next state: sweep every entry once, then stay READY until reset.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            INIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == AW'(DEPTH - 1)) begin
                    state_next = READY;
                end
            end
            READY: begin
                state_next = READY;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    // Outputs: the write port belongs to the fill sweep in INIT and to the loader in READY.
    always_comb begin
        mem_we    = 1'b0;
        mem_wa    = cnt_reg;
        mem_wd    = FILL;
        wr_rdy    = 1'b0;
        rd_accept = 1'b0;
        case (state_reg)
            INIT: begin
                mem_we = 1'b1;
            end
            READY: begin
                wr_rdy    = !lock;
                rd_accept = ra_vld;
                mem_we    = wr_vld && !lock;
                mem_wa    = wr_addr;
                mem_wd    = wr_data;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // Single write port; no reset on the array.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Registered read (read-first against a same-cycle write); rout holds between lookups.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rout_vld_reg <= 1'b0;
            rout_reg     <= '0;
        end else begin
            rout_vld_reg <= rd_accept;
            if (rd_accept) begin
                rout_reg <= mem[ra];
            end
        end
    end

    assign rout_vld  = rout_vld_reg;
    assign rout      = rout_reg;
    assign init_done = init_done_reg;

endmodule

// File: tb/tb_qs_ucode_store.sv
// Testbench for qs_ucode_store (DEPTH=256, W=16).
// Expected lookup results are queued when a lookup is driven and checked when rout_vld is due.
module tb_qs_ucode_store;

    localparam int          DEPTH = 256;
    localparam int          W     = 16;
    localparam int          AW    = 8;
    localparam logic [15:0] FILL  = 16'h1080;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ra_vld;
    logic [AW-1:0] ra;
    logic          rout_vld;
    logic [W-1:0]  rout;
    logic          wr_vld;
    logic          wr_rdy;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          lock;
    logic          init_done;

    qs_ucode_store #(.DEPTH(DEPTH), .W(W), .FILL(FILL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra_vld    (ra_vld),
        .ra        (ra),
        .rout_vld  (rout_vld),
        .rout      (rout),
        .wr_vld    (wr_vld),
        .wr_rdy    (wr_rdy),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .lock      (lock),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_exp = 16'h0;
    logic        mon_en = 1'b0;

    typedef struct {
        logic        rv;
        logic [7:0]  ra;
        logic        wv;
        logic [7:0]  wa;
        logic [15:0] wd;
        logic        lk;
        logic        exp_rdy;
        logic [15:0] exp_rout;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: one result due per queued lookup, otherwise rout_vld low and rout held.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("rout_vld", 32'(rout_vld), 32'd1);
                check("rout", 32'(rout), 32'(e));
                $display("lookup result rout=%h expected=%h", rout, e);
                last_exp = e;
            end else begin
                check("rout_vld_idle", 32'(rout_vld), 32'd0);
                check("rout_hold", 32'(rout), 32'(last_exp));
            end
        end
    end

    // One cycle of stimulus; inputs change 1 time unit after the rising edge.
    task automatic step(input logic rv, input logic [7:0] a, input logic wv, input logic [7:0] wa,
                        input logic [15:0] wd, input logic lk, input logic exp_rdy,
                        input logic [15:0] exp_rout);
        ra_vld  = rv;
        ra      = a;
        wr_vld  = wv;
        wr_addr = wa;
        wr_data = wd;
        lock    = lk;
        #1;
        check("wr_rdy", 32'(wr_rdy), 32'(exp_rdy));
        if (wv) $display("write addr=%0d data=%h lock=%0d wr_rdy=%0d", wa, wd, lk, wr_rdy);
        @(posedge clk);
        if (rv) exp_q.push_back(exp_rout);
        #1;
    endtask

    // Hold reset for cyc edges with a lookup pending; nothing may come out of it.
    task automatic do_reset(input int cyc);
        rst_n  = 1'b0;
        ra_vld = 1'b1;
        ra     = 8'd10;
        wr_vld = 1'b0;
        lock   = 1'b0;
        repeat (cyc) @(posedge clk);
        exp_q.delete();
        last_exp = 16'h0;
        mon_en   = 1'b1;
        #1;
        check("init_done_rst", 32'(init_done), 32'd0);
        check("wr_rdy_rst", 32'(wr_rdy), 32'd0);
        check("rout_vld_rst", 32'(rout_vld), 32'd0);
        check("rout_rst", 32'(rout), 32'd0);
        $display("reset applied for %0d cycle(s)", cyc);
        rst_n = 1'b1;
    endtask

    // Count cycles until init_done, with lookups and writes presented throughout INIT.
    task automatic wait_init();
        int n;
        n       = 0;
        wr_vld  = 1'b1;
        wr_addr = 8'd20;
        wr_data = 16'hDEAD;
        lock    = 1'b0;
        ra_vld  = 1'b1;
        while (n < 2000) begin
            ra = 8'($urandom);
            @(posedge clk);
            #1;
            n++;
            if (init_done) break;
            check("wr_rdy_init", 32'(wr_rdy), 32'd0);
        end
        ra_vld = 1'b0;
        wr_vld = 1'b0;
        check("init_latency", 32'(n), 32'(DEPTH));
        $display("init_done after %0d cycles", n);
    endtask

    initial begin
        rst_n   = 1'b0;
        ra_vld  = 1'b0;
        ra      = '0;
        wr_vld  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        lock    = 1'b0;

        //            rv  ra      wv  wa      wd         lk  rdy exp_rout
        vecs[0]  = '{1'b0, 8'd0,   1'b1, 8'd0,   16'h1020, 1'b0, 1'b1, 16'h0};
        vecs[1]  = '{1'b0, 8'd0,   1'b1, 8'd32,  16'hF000, 1'b0, 1'b1, 16'h0};
        vecs[2]  = '{1'b1, 8'd0,   1'b0, 8'd0,   16'h0,    1'b0, 1'b1, 16'h1020};
        vecs[3]  = '{1'b1, 8'd32,  1'b0, 8'd0,   16'h0,    1'b0, 1'b1, 16'hF000};
        vecs[4]  = '{1'b1, 8'd33,  1'b0, 8'd0,   16'h0,    1'b0, 1'b1, 16'h1080};
        vecs[5]  = '{1'b1, 8'd5,   1'b1, 8'd5,   16'h6001, 1'b0, 1'b1, 16'h1080};
        vecs[6]  = '{1'b1, 8'd5,   1'b0, 8'd0,   16'h0,    1'b0, 1'b1, 16'h6001};
        vecs[7]  = '{1'b0, 8'd0,   1'b1, 8'd7,   16'h7123, 1'b1, 1'b0, 16'h0};
        vecs[8]  = '{1'b1, 8'd7,   1'b0, 8'd0,   16'h0,    1'b1, 1'b0, 16'h1080};
        vecs[9]  = '{1'b0, 8'd0,   1'b1, 8'd7,   16'h7123, 1'b0, 1'b1, 16'h0};
        vecs[10] = '{1'b1, 8'd7,   1'b0, 8'd0,   16'h0,    1'b0, 1'b1, 16'h7123};
        vecs[11] = '{1'b1, 8'd0,   1'b1, 8'd9,   16'h9999, 1'b0, 1'b1, 16'h1020};
        vecs[12] = '{1'b1, 8'd9,   1'b0, 8'd0,   16'h0,    1'b0, 1'b1, 16'h9999};
        vecs[13] = '{1'b0, 8'd0,   1'b0, 8'd0,   16'h0,    1'b0, 1'b1, 16'h0};
        vecs[14] = '{1'b1, 8'd255, 1'b1, 8'd255, 16'hABCD, 1'b0, 1'b1, 16'h1080};
        vecs[15] = '{1'b1, 8'd255, 1'b1, 8'd10,  16'h4123, 1'b0, 1'b1, 16'hABCD};
        vecs[16] = '{1'b1, 8'd10,  1'b0, 8'd0,   16'h0,    1'b0, 1'b1, 16'h4123};
        vecs[17] = '{1'b0, 8'd0,   1'b0, 8'd0,   16'h0,    1'b0, 1'b1, 16'h0};

        // Power-up reset, fill, and first lookup right after init_done.
        do_reset(2);
        wait_init();
        step(1'b1, 8'd3, 1'b0, 8'd0, 16'h0, 1'b0, 1'b1, FILL);

        // Every entry reads back as FILL, back-to-back.
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b1, 8'(a), 1'b0, 8'd0, 16'h0, 1'b0, 1'b1, FILL);
        end

        // Loads, read-first, lock, and wrap cases from the vector table.
        for (int i = 0; i < 18; i++) begin
            step(vecs[i].rv, vecs[i].ra, vecs[i].wv, vecs[i].wa, vecs[i].wd,
                 vecs[i].lk, vecs[i].exp_rdy, vecs[i].exp_rout);
        end

        // A lookup presented on the reset edge must not produce a result; contents are refilled.
        do_reset(1);
        wait_init();
        step(1'b1, 8'd10,  1'b0, 8'd0, 16'h0, 1'b0, 1'b1, FILL);
        step(1'b1, 8'd0,   1'b0, 8'd0, 16'h0, 1'b0, 1'b1, FILL);
        step(1'b1, 8'd255, 1'b0, 8'd0, 16'h0, 1'b0, 1'b1, FILL);
        step(1'b1, 8'd20,  1'b0, 8'd0, 16'h0, 1'b0, 1'b1, FILL);
        step(1'b0, 8'd0,   1'b1, 8'd10, 16'h5555, 1'b0, 1'b1, 16'h0);

        // Reset in the middle of INIT restarts the full fill.
        do_reset(1);
        ra_vld = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        do_reset(1);
        wait_init();
        step(1'b1, 8'd10, 1'b0, 8'd0, 16'h0, 1'b0, 1'b1, FILL);
        step(1'b0, 8'd0,  1'b0, 8'd0, 16'h0, 1'b0, 1'b1, 16'h0);
        step(1'b0, 8'd0,  1'b0, 8'd0, 16'h0, 1'b0, 1'b1, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
